vector_mem_sequencer: RTL
=========================

# vector_mem_sequencer

Sequences multi-lane vector loads and stores onto the single-ported data memory in the MEM stage, one lane per cycle. Scalar loads and stores pass straight through. While a vector transfer is in progress the block holds the pipeline with `stall`. It sits between the MEM-stage control signals (`EnableRead`, `EnableWrite`, `MemRead`, `MemWrite`) and the data memory, and returns the assembled vector to the write-back path.

## Interface
Parameters:
- `LANES`, default 4: elements per vector register; must be 2 or more.
- `DATA_W`, default 32: element / scalar word width.
- `ADDR_W`, default 32: word address width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `vread_req`  in  1  vector load in the MEM stage (`EnableRead`).
- `vwrite_req`  in  1  vector store in the MEM stage (`EnableWrite`).
- `sread_req`  in  1  scalar load (`MemRead`).
- `swrite_req`  in  1  scalar store (`MemWrite`).
- `addr`  in  ADDR_W  ALU result: scalar address, or vector base address.
- `swdata`  in  DATA_W  scalar store data.
- `vwdata`  in  LANES*DATA_W  vector store data; lane i is bits [i*DATA_W +: DATA_W].
- `mem_addr`  out  ADDR_W  memory address.
- `mem_re`  out  1  memory read strobe.
- `mem_we`  out  1  memory write strobe.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid one cycle after `mem_re`.
- `srdata`  out  DATA_W  scalar load data; equal to `mem_rdata`.
- `vrdata`  out  LANES*DATA_W  assembled vector load data (registered).
- `vdone`  out  1  one-cycle pulse: vector operation complete.
- `stall`  out  1  holds the IF through MEM stages.

## Operation
- States:
  - IDLE
  - VREAD: issue lane reads
  - VDRAIN: capture the last read lane
  - VWRITE: issue lane writes
  - DONE
- IDLE:
  - If `vread_req` or `vwrite_req` is high: set `stall`=1 combinationally, latch `addr` into `base` and `vwdata` into a write buffer, clear `idx`, then go to VREAD or VWRITE.
  - `vread_req` has priority over `vwrite_req`.
  - With no vector request: pass-through. `mem_addr`=`addr`, `mem_re`=`sread_req`, `mem_we`=`swrite_req`, `mem_wdata`=`swdata`, `stall`=0.
  - Scalar requests are ignored whenever a vector request is present. The stall re-presents them later.
- VREAD:
  - Drive `mem_re`=1, `mem_addr`=`base`+`idx`.
  - From `idx`≥1, capture `mem_rdata` into lane `idx`-1.
  - Increment `idx`. After `idx`=LANES-1, go to VDRAIN.
- VDRAIN: capture lane LANES-1, no memory strobe, go to DONE.
- VWRITE:
  - Drive `mem_we`=1, `mem_addr`=`base`+`idx`, `mem_wdata`=buffer lane `idx`.
  - Increment `idx`. After `idx`=LANES-1, go to DONE.
- DONE:
  - `vdone`=1, `stall`=0, no memory strobe. Go to IDLE unconditionally.
  - Request inputs are ignored in DONE, because the same instruction is still present in the MEM stage.
- Address arithmetic: `base`+`idx` wraps modulo 2^ADDR_W.
- Input changes after entry from IDLE are ignored. Inputs are held anyway by the stall.

## Timing
- Reset:
  - Next state is IDLE.
  - `vrdata`=0, `idx`=0, `vdone`=0, `stall`=0.
  - `mem_re`=`mem_we`=0 while `rst`=1, in any state.
  - A reset during VWRITE aborts the transfer. No further lanes are written; lanes already written stay in memory.
- Vector load accepted in cycle T:
  - Lane reads are issued in cycles T+1 … T+LANES.
  - The last lane is captured at the end of T+LANES+1.
  - In T+LANES+2 (DONE): `vdone`=1 and `vrdata` is valid.
  - `stall`=1 from T through T+LANES+1, i.e. LANES+2 cycles.
- Vector store accepted in cycle T:
  - Lane writes are issued in cycles T+1 … T+LANES.
  - `vdone` is high in T+LANES+1.
  - `stall`=1 for LANES+1 cycles.
- Scalar access: zero added latency. `srdata` is valid in the cycle after `mem_re`.
- `vrdata` holds its value until the next vector load completes. It is not cleared by a store.
- Back-to-back vector operations: the second one is accepted in the first IDLE cycle after DONE.

## Structure
- Package `vmem_pkg`:
  - enum `vmem_state_t` with the states IDLE, VREAD, VDRAIN, VWRITE, DONE.
  - localparam `IDX_W` = $clog2(LANES).
- Optional sub-module `vmem_lane_counter`: `idx` register with clear/increment and a `last` flag.
- Everything else lives in a single always_ff block for state and registers, plus one always_comb block for the memory mux and strobes.

## Test plan
All scenarios use LANES=4.
- Vector load, base 0x10, memory words 0x10–0x13 = 0xA, 0xB, 0xC, 0xD:
  - `vrdata`={0xD,0xC,0xB,0xA}.
  - `stall` high for 6 cycles; `vdone` high at T+6.
  - `mem_re` high for exactly 4 cycles, with addresses 0x10 through 0x13.
- Vector store, base 0xFFFFFFFE, `vwdata`={4,3,2,1}:
  - Writes go to 0xFFFFFFFE=1, 0xFFFFFFFF=2, 0x0=3, 0x1=4.
  - `stall` high for 5 cycles.
- Scalar load from 0x20 (holding 0x55) with no vector request:
  - `mem_re`=1 and `stall`=0 in the request cycle.
  - `srdata`=0x55 in the next cycle.
  - Scalar store then writes `swdata` in the same cycle.
- `rst` asserted in VWRITE after 2 lanes are written:
  - Only 2 writes occur, with no strobe in the reset cycle.
  - `stall`=0 and the state is IDLE in the following cycle.
- `vread_req` and `sread_req` high together: the vector load runs and no scalar strobe is issued. Then `vread_req` and `vwrite_req` together: the load is performed.
- Vector load immediately followed by a vector store:
  - The store is accepted in the cycle after DONE.
  - `vrdata` is unchanged by the store.
  - `vdone` pulses twice, each pulse exactly 1 cycle wide.

Source files
------------

// File: rtl/vector_mem_sequencer_pkg.sv
// Shared types and sizing for the MEM-stage vector memory sequencer.
package vmem_pkg;

  localparam int unsigned DEF_LANES = 4;
  localparam int unsigned IDX_W     = $clog2(DEF_LANES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VREAD  = 3'd1,
    VDRAIN = 3'd2,
    VWRITE = 3'd3,
    DONE   = 3'd4
  } vmem_state_t;

endpackage

// File: rtl/vector_mem_sequencer_lane_counter.sv
// Lane index counter: cleared on vector entry, stepped once per issued lane.
module vmem_lane_counter #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] idx,
  output logic             last_c
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + CNT_W'(1);
    end
  end

  assign last_c = (idx == CNT_W'(LANES - 1));

endmodule

// File: rtl/vector_mem_sequencer.sv
// Serialises vector loads/stores onto a single-ported data memory one lane per
// cycle, stalling the pipeline meanwhile; scalar accesses pass straight through.
module vector_mem_sequencer
  import vmem_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vread_req,
  input  logic                    vwrite_req,
  input  logic                    sread_req,
  input  logic                    swrite_req,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       swdata,
  input  logic [LANES*DATA_W-1:0] vwdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [DATA_W-1:0]       srdata,
  output logic [LANES*DATA_W-1:0] vrdata,
  output logic                    vdone,
  output logic                    stall
);

  localparam int unsigned CNT_W = $clog2(LANES);
  localparam int unsigned VEC_W = LANES * DATA_W;

  vmem_state_t       state, state_nx;
  logic [ADDR_W-1:0] base;
  logic [VEC_W-1:0]  lane_buf;
  logic [CNT_W-1:0]  idx;
  logic              last_c;
  logic              clr;
  logic              inc;
  logic              vreq;
  logic [DATA_W-1:0] lane_wdata;

  assign vreq   = vread_req | vwrite_req;
  assign srdata = mem_rdata;

  vmem_lane_counter #(
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) u_lane_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .inc    (inc),
    .idx    (idx),
    .last_c (last_c)
  );

  // Next state, memory mux and strobes; strobes and stall are forced low in reset.
  always_comb begin
    state_nx   = state;
    clr        = 1'b0;
    inc        = 1'b0;
    stall      = 1'b0;
    mem_addr   = addr;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = swdata;
    lane_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx == CNT_W'(i)) lane_wdata = lane_buf[i*DATA_W +: DATA_W];
    end
    case (state)
      IDLE: begin
        if (vreq) begin
          stall    = 1'b1;
          clr      = 1'b1;
          state_nx = vread_req ? VREAD : VWRITE;
        end else begin
          mem_re = sread_req;
          mem_we = swrite_req;
        end
      end
      VREAD: begin
        stall    = 1'b1;
        inc      = 1'b1;
        mem_re   = 1'b1;
        mem_addr = base + ADDR_W'(idx);
        if (last_c) state_nx = VDRAIN;
      end
      VDRAIN: begin
        stall    = 1'b1;
        state_nx = DONE;
      end
      VWRITE: begin
        stall     = 1'b1;
        inc       = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base + ADDR_W'(idx);
        mem_wdata = lane_wdata;
        if (last_c) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (rst) begin
      mem_re = 1'b0;
      mem_we = 1'b0;
      stall  = 1'b0;
    end
  end

  // Read lanes land in lane_buf one cycle after issue; vrdata updates only on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      lane_buf <= '0;
      vrdata   <= '0;
      vdone    <= 1'b0;
    end else begin
      state <= state_nx;
      vdone <= (state_nx == DONE);
      if (state == IDLE && vreq) begin
        base     <= addr;
        lane_buf <= vwdata;
      end
      if (state == VREAD) begin
        for (int i = 0; i < LANES - 1; i++) begin
          if (idx == CNT_W'(i + 1)) lane_buf[i*DATA_W +: DATA_W] <= mem_rdata;
        end
      end
      if (state == VDRAIN) begin
        vrdata <= {mem_rdata, lane_buf[(LANES-1)*DATA_W-1:0]};
      end
    end
  end

endmodule
